// File: rtl/nand_seq_unit.sv
// Time-multiplexed logic-function sequencer: evaluates NAND/AND/OR/NOT/XOR/XNOR
// on captured operands through one shared bitwise NAND, one micro-step per cycle.
module nand_seq_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned STEP_W = 3;
    localparam int unsigned OP_W   = 3;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(5);

    typedef enum logic {IDLE, EXEC} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_T2, SRC_T3} src_t;
    typedef enum logic [2:0] {DST_T0, DST_T1, DST_T2, DST_T3, DST_RES} dst_t;

    state_t             state, state_nx;
    logic [STEP_W-1:0]  step, step_nx;
    logic [OP_W-1:0]    op_q, op_nx;
    logic [WIDTH-1:0]   a_q, a_nx, b_q, b_nx;
    logic [WIDTH-1:0]   t0, t1, t2, t3, t0_nx, t1_nx, t2_nx, t3_nx;
    logic [WIDTH-1:0]   result_nx;
    logic               busy_nx, done_nx, err_nx;

    src_t               sel_x, sel_z;
    dst_t               dst;
    logic [WIDTH-1:0]   x, z, y;

    // Micro-step schedule: operand sources and destination per (op, step)
    always_comb begin
        sel_x = SRC_A;
        sel_z = SRC_B;
        dst   = DST_RES;
        case (op_q)
            3'd1: case (step)
                3'd1:    begin sel_x = SRC_A;  sel_z = SRC_B;  dst = DST_T0;  end
                default: begin sel_x = SRC_T0; sel_z = SRC_T0; dst = DST_RES; end
            endcase
            3'd2: case (step)
                3'd1:    begin sel_x = SRC_A;  sel_z = SRC_A;  dst = DST_T0;  end
                3'd2:    begin sel_x = SRC_B;  sel_z = SRC_B;  dst = DST_T1;  end
                default: begin sel_x = SRC_T0; sel_z = SRC_T1; dst = DST_RES; end
            endcase
            3'd3: begin sel_x = SRC_A; sel_z = SRC_A; dst = DST_RES; end
            3'd4: case (step)
                3'd1:    begin sel_x = SRC_A;  sel_z = SRC_A;  dst = DST_T0;  end
                3'd2:    begin sel_x = SRC_B;  sel_z = SRC_B;  dst = DST_T1;  end
                3'd3:    begin sel_x = SRC_T0; sel_z = SRC_B;  dst = DST_T2;  end
                3'd4:    begin sel_x = SRC_A;  sel_z = SRC_T1; dst = DST_T3;  end
                default: begin sel_x = SRC_T2; sel_z = SRC_T3; dst = DST_RES; end
            endcase
            3'd5: case (step)
                3'd1:    begin sel_x = SRC_A;  sel_z = SRC_A;  dst = DST_T0;  end
                3'd2:    begin sel_x = SRC_B;  sel_z = SRC_B;  dst = DST_T1;  end
                3'd3:    begin sel_x = SRC_A;  sel_z = SRC_B;  dst = DST_T2;  end
                3'd4:    begin sel_x = SRC_T0; sel_z = SRC_T1; dst = DST_T3;  end
                default: begin sel_x = SRC_T2; sel_z = SRC_T3; dst = DST_RES; end
            endcase
            default: begin sel_x = SRC_A; sel_z = SRC_B; dst = DST_RES; end
        endcase
    end

    // Operand routing into the shared NAND unit
    always_comb begin
        case (sel_x)
            SRC_A:   x = a_q;
            SRC_B:   x = b_q;
            SRC_T0:  x = t0;
            SRC_T1:  x = t1;
            SRC_T2:  x = t2;
            default: x = t3;
        endcase
        case (sel_z)
            SRC_A:   z = a_q;
            SRC_B:   z = b_q;
            SRC_T0:  z = t0;
            SRC_T1:  z = t1;
            SRC_T2:  z = t2;
            default: z = t3;
        endcase
        y = ~(x & z);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state;
        step_nx   = step;
        op_nx     = op_q;
        a_nx      = a_q;
        b_nx      = b_q;
        t0_nx     = t0;
        t1_nx     = t1;
        t2_nx     = t2;
        t3_nx     = t3;
        result_nx = result;
        busy_nx   = busy;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nx    = a;
                    b_nx    = b;
                    op_nx   = op;
                    step_nx = STEP_W'(1);
                    if (op <= OP_LAST_LEGAL) begin
                        state_nx = EXEC;
                        busy_nx  = 1'b1;
                    end else begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                    end
                end
            end
            EXEC: begin
                case (dst)
                    DST_T0:  t0_nx = y;
                    DST_T1:  t1_nx = y;
                    DST_T2:  t2_nx = y;
                    DST_T3:  t3_nx = y;
                    default: result_nx = y;
                endcase
                if (dst == DST_RES) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    step_nx = step + STEP_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            t0     <= '0;
            t1     <= '0;
            t2     <= '0;
            t3     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            step   <= step_nx;
            op_q   <= op_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            t0     <= t0_nx;
            t1     <= t1_nx;
            t2     <= t2_nx;
            t3     <= t3_nx;
            result <= result_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_nand_seq_unit.sv
// Bench for nand_seq_unit: directed plan plus randomized ops against a
// truth-level reference; a WIDTH=1 instance is checked exhaustively.
module tb_nand_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       busy, done, err;
    logic [7:0] result;

    logic       start1;
    logic [2:0] op1;
    logic       a1, b1;
    logic       busy1, done1, err1;
    logic       result1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_res;
    logic [7:0] kexp [6] = '{8'h77, 8'h88, 8'hEE, 8'h33, 8'h66, 8'h99};

    always #5 clk = ~clk;

    nand_seq_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    nand_seq_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .err(err1), .result(result1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return ~(x & y);
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return ~x;
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            default: return 8'h00;
        endcase
    endfunction

    // Clock edges from acceptance to done; illegal ops report in the cycle right after acceptance
    function automatic int latency(input logic [2:0] o);
        case (o)
            3'd0, 3'd3: return 1;
            3'd1:       return 2;
            3'd2:       return 3;
            3'd4, 3'd5: return 5;
            default:    return 0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit intrude);
        int n;
        bit seen;
        bit legal;
        legal = (o <= 3'd5);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        n = -1;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            else check("busy_exec", 32'(busy), 32'(legal));
            if (!seen && intrude) begin
                start = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        if (legal) exp_res = model(o, x, y);
        check("latency", 32'(n), 32'(latency(o)));
        check("result", 32'(result), 32'(exp_res));
        check("err_at_done", 32'(err), 32'(!legal));
        check("busy_at_done", 32'(busy), 32'(0));
        @(negedge clk);
        check("done_single", 32'(done), 32'(0));
        check("err_single", 32'(err), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        int n;
        bit spurious;
        logic [7:0] w;

        rst_n = 1'b0;
        start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        start1 = 1'b0; op1 = 3'd0; a1 = 1'b0; b1 = 1'b0;
        exp_res = 8'h00;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_busy1", 32'(busy1), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(3'(i), 8'hCC, 8'hAA, 1'b0);
            check("directed", 32'(result), 32'(kexp[i]));
        end

        run_op(3'd4, 8'hF0, 8'h0F, 1'b1);
        check("xor_intrude", 32'(result), 32'(8'hFF));

        // AND then OR accepted in the AND done cycle
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 8'hFF; b = 8'h0F;
        n = -1;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end while (done !== 1'b1 && n < 10);
        check("b2b_and_lat", 32'(n), 32'(2));
        check("b2b_and_res", 32'(result), 32'(8'h0F));
        start = 1'b1; op = 3'd2; a = 8'h00; b = 8'h00;
        n = -1;
        do begin
            @(negedge clk);
            n++;
            if (n == 0) check("b2b_no_gap", 32'(busy), 32'(1));
            start = 1'b0;
        end while (done !== 1'b1 && n < 10);
        check("b2b_or_lat", 32'(n), 32'(3));
        check("b2b_or_res", 32'(result), 32'(8'h00));
        exp_res = 8'h00;
        @(negedge clk);
        check("b2b_done_single", 32'(done), 32'(0));

        run_op(3'd5, 8'hCC, 8'hAA, 1'b0);
        run_op(3'd6, 8'h12, 8'h34, 1'b0);
        check("illegal_hold", 32'(result), 32'(8'h99));

        // Reset while XNOR step 3 is evaluating
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 8'hCC; b = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_err", 32'(err), 32'(0));
        check("mid_rst_result", 32'(result), 32'(0));
        exp_res = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        check("no_done_after_rst", 32'(spurious), 32'(0));
        run_op(3'd0, 8'hFF, 8'hFF, 1'b0);
        check("nand_after_rst", 32'(result), 32'(8'h00));

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        for (int o = 0; o < 6; o++) begin
            for (int v = 0; v < 4; v++) begin
                @(negedge clk);
                start1 = 1'b1; op1 = 3'(o); a1 = 1'(v >> 1); b1 = 1'(v);
                n = -1;
                do begin
                    @(negedge clk);
                    n++;
                    start1 = 1'b0;
                end while (done1 !== 1'b1 && n < 10);
                w = model(3'(o), {7'd0, 1'(v >> 1)}, {7'd0, 1'(v)});
                check("w1_done", 32'(done1), 32'(1));
                check("w1_result", 32'(result1), 32'(w[0]));
                check("w1_lat", 32'(n), 32'(latency(3'(o))));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
